ysyx_25040105_core_seq: RTL
===========================

# ysyx_25040105_core_seq

Multi-cycle instruction sequencer that replaces the single-cycle top-level control of the ysyx_25040105 core. It owns the PC and fetches through a req/ack instruction port with variable latency. It issues a one-cycle execute strobe to the IDU/EXU/register-file datapath, detects `ebreak` and latches the exit code from a0. It also buffers committed (pc, inst) pairs in a parametrised trace FIFO that the simulation harness drains with valid/ready.

## Interface
Parameters:
- XLEN, 32, datapath/PC width
- RESET_PC, 32'h8000_0000, PC value after reset
- TRACE_DEPTH, 8, trace FIFO entries; power of two, ≥2
- FETCH_TIMEOUT, 255, max cycles `ifu_req` may wait for `ifu_ack` before a timeout halt; ≥1

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  reset, asynchronous and active-low
- ifu_req  out  1  fetch request, held high while waiting for ack
- ifu_addr  out  XLEN  fetch address; equals `pc`
- ifu_ack  in  1  fetch data valid this cycle
- ifu_inst  in  32  fetched instruction, sampled when `ifu_req && ifu_ack`
- pc  out  XLEN  current PC
- inst  out  32  instruction register fed to the IDU
- next_pc  in  XLEN  next PC from the EXU (pc+4 or jump target)
- a0  in  XLEN  register x10, read at ebreak
- exec_en  out  1  one-cycle strobe; gates register-file write enable
- halt  out  1  sticky stop flag
- exit_code  out  XLEN  a0 value at ebreak; all-ones on timeout
- good_trap  out  1  halt caused by ebreak with a0==0
- timeout  out  1  halt caused by fetch timeout
- trace_valid  out  1  FIFO non-empty
- trace_ready  in  1  harness pops the head when valid && ready
- trace_pc  out  XLEN  head entry PC
- trace_inst  out  32  head entry instruction
- commit_cnt  out  64  retired-instruction count

## Operation
- FSM states: FETCH, EXEC, HALT.
- Reset (rst=0) values:
  - FSM returns to FETCH.
  - pc=RESET_PC, inst=0, exit_code=0, commit_cnt=0.
  - All flags 0, FIFO empty, wait counter 0.
- FETCH:
  - `ifu_req`=1.
  - On ack: inst←ifu_inst, wait counter←0, go to EXEC.
  - Otherwise the wait counter increments. When it reaches FETCH_TIMEOUT without an ack: timeout=1, halt=1, exit_code=all-ones, go to HALT.
- EXEC:
  - Commit is allowed when the FIFO is not full, or a pop occurs in the same cycle.
  - If commit is allowed:
    - exec_en=1 for this cycle.
    - Push (pc, inst) into the FIFO; commit_cnt+1.
    - If inst==32'h0010_0073 (ebreak): exit_code←a0, good_trap←(a0==0), halt←1, go to HALT. pc is not updated.
    - Otherwise pc←next_pc and go to FETCH.
  - If commit is not allowed: stay in EXEC with exec_en=0 and no state change.
- HALT:
  - Terminal until reset; ifu_req=0, exec_en=0, pc frozen.
  - The FIFO continues to drain.
- FIFO:
  - Circular buffer with log2(TRACE_DEPTH)-bit pointers that wrap modulo depth, plus a count of width log2(TRACE_DEPTH)+1.
  - Push and pop in the same cycle leave the count unchanged.
  - A pop on empty is ignored.
  - Outputs come from the head registers; trace_pc/trace_inst are don't-care when trace_valid=0.
- commit_cnt wraps modulo 2^64.
- Asserting rst mid-fetch or mid-EXEC aborts immediately. No exec_en pulse is produced for the aborted instruction, and FIFO contents are lost.

## Timing
- Minimum of 2 cycles per instruction: ack in the first FETCH cycle, then EXEC.
- Fetch latency of L cycles (ack L cycles after req rises) gives L+2 cycles per instruction.
- ifu_addr is stable during the whole request; ifu_req drops the cycle after ack is sampled.
- exec_en is asserted combinationally in EXEC. The datapath writes rd on the same edge that updates pc.
- Trace entry visibility: trace_valid rises the cycle after the commit edge.
- halt, good_trap and timeout become visible the cycle after the ebreak commit or the timeout edge.
- Timeout boundary: if ack arrives in the same cycle the counter would reach FETCH_TIMEOUT, the ack wins.

## Test plan
- **Straight-line fetch:** ack every cycle with 4 addi instructions (next_pc=pc+4).
  - pc sequence 8000_0000, …04, …08, …0C.
  - One exec_en per 2 cycles; commit_cnt=4.
- **Jump and latency:** ack delayed 3 cycles, next_pc=8000_0100.
  - ifu_req held 4 cycles; pc becomes 8000_0100 after EXEC.
- **Ebreak:**
  - a0=0: halt=1, good_trap=1, exit_code=0, ifu_req stays 0 afterwards.
  - a0=5 (separate run): good_trap=0, exit_code=5.
- **FIFO backpressure:** TRACE_DEPTH=4, trace_ready=0, 6 instructions.
  - Commits stall in EXEC after 4 entries with exec_en=0.
  - Raising trace_ready resumes execution; the harness sees entries in order with no loss.
  - Same-cycle push/pop when full keeps count=4.
- **Timeout:** FETCH_TIMEOUT=10, ack never arrives.
  - Halt with timeout=1 and exit_code=FFFF_FFFF on the 10th wait cycle.
  - Ack on exactly cycle 10 is accepted instead.
- **Reset mid-operation:** drop rst during EXEC with 2 FIFO entries.
  - All outputs return to reset values asynchronously, trace_valid=0, pc=8000_0000.

Source files
------------

// File: rtl/ysyx_25040105_core_seq.sv
// ysyx_25040105_core_seq: multi-cycle fetch/execute sequencer with ebreak halt, fetch timeout and commit trace FIFO
module ysyx_25040105_core_seq #(
  parameter int              XLEN          = 32,
  parameter logic [XLEN-1:0] RESET_PC      = 32'h8000_0000,
  parameter int              TRACE_DEPTH   = 8,
  parameter int              FETCH_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_req,
  output logic [XLEN-1:0] ifu_addr,
  input  logic            ifu_ack,
  input  logic [31:0]     ifu_inst,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     inst,
  input  logic [XLEN-1:0] next_pc,
  input  logic [XLEN-1:0] a0,
  output logic            exec_en,
  output logic            halt,
  output logic [XLEN-1:0] exit_code,
  output logic            good_trap,
  output logic            timeout,
  output logic            trace_valid,
  input  logic            trace_ready,
  output logic [XLEN-1:0] trace_pc,
  output logic [31:0]     trace_inst,
  output logic [63:0]     commit_cnt
);
  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int CW = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [AW:0]   FULL     = (AW + 1)'(TRACE_DEPTH);
  localparam logic [CW-1:0] WAIT_MAX = CW'(FETCH_TIMEOUT - 1);
  localparam logic [31:0]   EBREAK   = 32'h0010_0073;
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [XLEN-1:0] pc_mem   [TRACE_DEPTH];
  logic [31:0]     inst_mem [TRACE_DEPTH];
  logic            pop, commit_ok;
  assign trace_valid = count != '0;
  assign pop         = trace_valid && trace_ready;
  assign commit_ok   = count != FULL || pop;
  assign exec_en     = state == EXEC && commit_ok;
  assign ifu_req     = state == FETCH;
  assign ifu_addr    = pc;
  assign trace_pc    = pc_mem[rd_ptr];
  assign trace_inst  = inst_mem[rd_ptr];
  // sequencer: fetch handshake with timeout, commit on a free FIFO slot, sticky halt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      inst       <= '0;
      exit_code  <= '0;
      commit_cnt <= '0;
      halt       <= 1'b0;
      good_trap  <= 1'b0;
      timeout    <= 1'b0;
      wait_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(exec_en);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW + 1)'(exec_en) - (AW + 1)'(pop);
      case (state)
        FETCH:
          if (ifu_ack) begin
            inst     <= ifu_inst;
            wait_cnt <= '0;
            state    <= EXEC;
          end else if (wait_cnt == WAIT_MAX) begin
            timeout   <= 1'b1;
            halt      <= 1'b1;
            exit_code <= '1;
            state     <= HALT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        EXEC:
          if (commit_ok) begin
            commit_cnt <= commit_cnt + 64'd1;
            if (inst == EBREAK) begin
              exit_code <= a0;
              good_trap <= a0 == '0;
              halt      <= 1'b1;
              state     <= HALT;
            end else begin
              pc    <= next_pc;
              state <= FETCH;
            end
          end
        default: ;
      endcase
    end
  end
  // trace storage: written at the commit slot, no reset needed since count gates visibility
  always_ff @(posedge clk) begin
    if (exec_en) begin
      pc_mem[wr_ptr]   <= pc;
      inst_mem[wr_ptr] <= inst;
    end
  end
endmodule
